wm_phase_timer: RTL and testbench

- Cycle countdown timer for the washing-machine controller; sits directly downstream of the per-state duration lookup.
- Takes the four per-phase cycle counts and the current controller state. Loads the count for the active phase on every phase entry, counts it down, and returns a one-cycle timeout pulse to the controller FSM to advance the phase.
- Supports pause (door-open / user pause) and forced restart of the current phase.

---
 rtl/wm_phase_timer.sv | 66 ++++++
 tb/tb_wm_phase_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wm_phase_timer.sv
// Per-phase cycle countdown for the washing-machine controller.
// Reloads on phase entry or restart, counts down, pulses timeout once at expiry.
module wm_phase_timer #(
   parameter int COUNT_W = 29
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         state,
   input  logic [COUNT_W-1:0] filling_count,
   input  logic [COUNT_W-1:0] washing_count,
   input  logic [COUNT_W-1:0] rinsing_count,
   input  logic [COUNT_W-1:0] spinning_count,
   input  logic               timer_pause,
   input  logic               timer_restart,
   output logic               timeout,
   output logic               busy,
   output logic [COUNT_W-1:0] remaining
);

   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   logic [2:0]         state_q;
   logic [COUNT_W-1:0] counter;
   logic [COUNT_W-1:0] sel;
   logic               load;

   always_comb begin
      sel = '0;
      case (state)
         3'b001:  sel = filling_count;
         3'b010:  sel = washing_count;
         3'b011:  sel = rinsing_count;
         3'b100:  sel = spinning_count;
         default: sel = '0;
      endcase
   end

   // raw state code is tracked so any code change, including idle aliases, reloads
   assign load = (state != state_q) || timer_restart;

   always_ff @(posedge clk) begin
      if (rst) begin
         counter <= '0;
         state_q <= 3'b000;
         timeout <= 1'b0;
      end else if (load) begin
         counter <= sel;
         state_q <= state;
         timeout <= 1'b0;
      end else if (timer_pause) begin
         timeout <= 1'b0;
      end else if (counter > ONE) begin
         counter <= counter - ONE;
         timeout <= 1'b0;
      end else if (counter == ONE) begin
         counter <= '0;
         timeout <= 1'b1;
      end else begin
         timeout <= 1'b0;
      end
   end

   assign busy      = (counter != '0);
   assign remaining = counter;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: load, countdown, pause, abort, restart, reset.
module tb_wm_phase_timer;

   localparam int COUNT_W = 29;

   logic               clk = 1'b0;
   logic               rst;
   logic [2:0]         state;
   logic [COUNT_W-1:0] filling_count, washing_count, rinsing_count, spinning_count;
   logic               timer_pause, timer_restart;
   logic               timeout, busy;
   logic [COUNT_W-1:0] remaining;

   int checks   = 0;
   int failures = 0;

   wm_phase_timer #(.COUNT_W(COUNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .state          (state),
      .filling_count  (filling_count),
      .washing_count  (washing_count),
      .rinsing_count  (rinsing_count),
      .spinning_count (spinning_count),
      .timer_pause    (timer_pause),
      .timer_restart  (timer_restart),
      .timeout        (timeout),
      .busy           (busy),
      .remaining      (remaining)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int rem, input bit to);
      chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
      chk({tag, ".timeout"},   32'(timeout),   32'(to));
      chk({tag, ".busy"},      32'(busy),      32'(rem != 0));
   endtask

   initial begin
      rst = 1'b1; state = 3'b000; timer_pause = 1'b0; timer_restart = 1'b0;
      filling_count = 5; washing_count = 10; rinsing_count = 3; spinning_count = 6;
      step();
      step();
      chk_all("reset", 0, 0);

      // filling for 5 cycles
      rst = 1'b0; state = 3'b001;
      step();
      chk_all("fill_load", 5, 0);
      for (int k = 4; k >= 0; k--) begin
         step();
         chk_all($sformatf("fill_%0d", k), k, k == 0);
      end
      step();
      chk_all("fill_after", 0, 0);

      // washing 10 with a 4-cycle pause at 7
      state = 3'b010;
      step();
      chk_all("wash_load", 10, 0);
      for (int k = 9; k >= 7; k--) begin
         step();
         chk_all($sformatf("wash_%0d", k), k, 0);
      end
      timer_pause = 1'b1;
      for (int p = 0; p < 4; p++) begin
         step();
         chk_all($sformatf("wash_pause%0d", p), 7, 0);
      end
      timer_pause = 1'b0;
      for (int k = 6; k >= 0; k--) begin
         step();
         chk_all($sformatf("wash_%0d", k), k, k == 0);
      end

      // rinsing aborted at remaining==1 by switch to spinning
      state = 3'b011;
      step();
      chk_all("rinse_load", 3, 0);
      step();
      step();
      chk_all("rinse_1", 1, 0);
      state = 3'b100;
      step();
      chk_all("abort_spin_load", 6, 0);
      for (int k = 5; k >= 0; k--) begin
         step();
         chk_all($sformatf("spin_%0d", k), k, k == 0);
      end

      // idle and illegal codes never count
      state = 3'b000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("idle_%0d", i), 0, 0);
      end
      state = 3'b110;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("illegal_%0d", i), 0, 0);
      end

      // spinning 8 with restart after 5 cycles; count change mid-phase ignored
      spinning_count = 8; state = 3'b100;
      step();
      chk_all("spin8_load", 8, 0);
      for (int k = 7; k >= 3; k--) begin
         step();
         chk_all($sformatf("spin8_%0d", k), k, 0);
      end
      timer_restart = 1'b1;
      step();
      chk_all("restart_load", 8, 0);
      timer_restart = 1'b0; spinning_count = 2;
      for (int k = 7; k >= 0; k--) begin
         step();
         chk_all($sformatf("restart_%0d", k), k, k == 0);
      end
      step();
      chk_all("no_autoreload", 0, 0);

      // reset mid-phase, then reload from full count
      state = 3'b001; filling_count = 5;
      step();
      chk_all("fill2_load", 5, 0);
      step();
      chk_all("fill2_4", 4, 0);
      rst = 1'b1;
      step();
      chk_all("midreset", 0, 0);
      rst = 1'b0;
      step();
      chk_all("postreset_load", 5, 0);
      for (int k = 4; k >= 0; k--) begin
         step();
         chk_all($sformatf("postreset_%0d", k), k, k == 0);
      end

      // pause does not block a load
      timer_pause = 1'b1; washing_count = 3; state = 3'b010;
      step();
      chk_all("pause_load", 3, 0);
      step();
      chk_all("pause_hold", 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
